// File: rtl/alu_operand_stage.sv
// Execute-stage operand register feeding the ALU: valid/ready capture, stall hold,
// flush, opcode sanitising and MEM/WB forwarding (enabled by ALU_OPERAND_FWD_EN).
`timescale 1ns/1ps
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_alu_control,
  input  logic [REGW-1:0] in_rs1_addr,
  input  logic [REGW-1:0] in_rs2_addr,
  input  logic [REGW-1:0] in_rd_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic            flush,
  input  logic            mem_fwd_we,
  input  logic            wb_fwd_we,
  input  logic [REGW-1:0] mem_fwd_addr,
  input  logic [REGW-1:0] wb_fwd_addr,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [2:0]      ALU_control,
  output logic [REGW-1:0] out_rd_addr
);

  logic            valid;
  logic [2:0]      alu_control;
  logic [REGW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic            use_imm;
  logic            load;
  logic [XLEN-1:0] fwd1, fwd2;

  assign in_ready = !valid || out_ready;
  // A flushed offer is dropped entirely: neither valid nor the fields update.
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      alu_control <= '0;
      rs1_addr    <= '0;
      rs2_addr    <= '0;
      rd_addr     <= '0;
      rs1_data    <= '0;
      rs2_data    <= '0;
      imm         <= '0;
      use_imm     <= 1'b0;
    end else begin
      if (flush)          valid <= 1'b0;
      else if (load)      valid <= 1'b1;
      else if (out_ready) valid <= 1'b0;
      if (load) begin
        alu_control <= (in_alu_control[2:1] == 2'b11) ? 3'b000 : in_alu_control;
        rs1_addr    <= in_rs1_addr;
        rs2_addr    <= in_rs2_addr;
        rd_addr     <= in_rd_addr;
        rs1_data    <= in_rs1_data;
        rs2_data    <= in_rs2_data;
        imm         <= in_imm;
        use_imm     <= in_use_imm;
      end
    end
  end

`ifdef ALU_OPERAND_FWD_EN
  // MEM is the younger result, so it takes priority over WB; x0 is never forwarded.
  always_comb begin
    fwd1 = rs1_data;
    if (mem_fwd_we && (mem_fwd_addr == rs1_addr) && (rs1_addr != '0))
      fwd1 = mem_fwd_data;
    else if (wb_fwd_we && (wb_fwd_addr == rs1_addr) && (rs1_addr != '0))
      fwd1 = wb_fwd_data;
  end

  always_comb begin
    fwd2 = rs2_data;
    if (mem_fwd_we && (mem_fwd_addr == rs2_addr) && (rs2_addr != '0))
      fwd2 = mem_fwd_data;
    else if (wb_fwd_we && (wb_fwd_addr == rs2_addr) && (rs2_addr != '0))
      fwd2 = wb_fwd_data;
  end
`else
  logic unused_fwd;

  assign fwd1 = rs1_data;
  assign fwd2 = rs2_data;
  assign unused_fwd = ^{mem_fwd_we, wb_fwd_we, mem_fwd_addr, wb_fwd_addr,
                        mem_fwd_data, wb_fwd_data, rs1_addr, rs2_addr};
`endif

  assign out_valid   = valid;
  assign A           = fwd1;
  assign B           = use_imm ? imm : fwd2;
  assign ALU_control = alu_control;
  assign out_rd_addr = rd_addr;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_alu_operand_stage;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_op;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  instr_t      cur;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_addr, wb_fwd_addr, out_rd_addr;
  logic [31:0] mem_fwd_data, wb_fwd_data, A, B;
  logic [2:0]  ALU_control;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: the instruction currently presented, and whether it is live.
  logic   m_valid;
  instr_t m_held;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_control(cur.op), .in_rs1_addr(cur.rs1), .in_rs2_addr(cur.rs2),
    .in_rd_addr(cur.rd), .in_rs1_data(cur.d1), .in_rs2_data(cur.d2),
    .in_imm(cur.imm), .in_use_imm(cur.use_imm), .flush(flush),
    .mem_fwd_we(mem_fwd_we), .wb_fwd_we(wb_fwd_we),
    .mem_fwd_addr(mem_fwd_addr), .wb_fwd_addr(wb_fwd_addr),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B),
    .ALU_control(ALU_control), .out_rd_addr(out_rd_addr)
  );

  function automatic instr_t mk(logic [2:0] op, logic [4:0] rs1, logic [31:0] d1,
                                logic [4:0] rs2, logic [31:0] d2, logic [4:0] rd,
                                logic [31:0] imm, logic use_imm);
    instr_t i;
    i.op = op; i.rs1 = rs1; i.d1 = d1; i.rs2 = rs2; i.d2 = d2;
    i.rd = rd; i.imm = imm; i.use_imm = use_imm;
    return i;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value a source register reads after bypassing: youngest live producer wins.
  function automatic logic [31:0] src_value(logic [4:0] a, logic [31:0] d);
`ifdef ALU_OPERAND_FWD_EN
    if (a != 0 && mem_fwd_we && mem_fwd_addr == a) return mem_fwd_data;
    if (a != 0 && wb_fwd_we && wb_fwd_addr == a) return wb_fwd_data;
`endif
    return d;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_held  = '0;
  endtask

  task automatic check_model(string tag);
    chk({tag, "/out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "/in_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
    chk({tag, "/ALU_control"}, 32'(ALU_control), 32'(m_held.op));
    chk({tag, "/rd"}, 32'(out_rd_addr), 32'(m_held.rd));
    chk({tag, "/A"}, A, src_value(m_held.rs1, m_held.d1));
    chk({tag, "/B"}, B, m_held.use_imm ? m_held.imm : src_value(m_held.rs2, m_held.d2));
  endtask

  // Advance one clock; the model sees the same pre-edge inputs as the DUT.
  task automatic cycle();
    instr_t s;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (flush) m_valid = 1'b0;
    else if (in_valid && (!m_valid || out_ready)) begin
      s = cur;
      if (s.op > 3'd5) s.op = 3'd0;
      m_held  = s;
      m_valid = 1'b1;
    end else if (out_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic no_fwd();
    mem_fwd_we = 0; wb_fwd_we = 0;
    mem_fwd_addr = 0; wb_fwd_addr = 0;
    mem_fwd_data = 0; wb_fwd_data = 0;
  endtask

  vec_t   vecs[6];
  instr_t i1, i2;

  initial begin
    vecs[0] = '{mk(3'd1, 5'd3, 32'h10, 5'd4, 32'h20, 5'd7, 32'h5, 1'b0), 32'h10, 32'h20, 3'd1};
    vecs[1] = '{mk(3'd7, 5'd1, 32'h1234, 5'd2, 32'h99, 5'd8, 32'hFFFF_FFF0, 1'b1), 32'h1234, 32'hFFFF_FFF0, 3'd0};
    vecs[2] = '{mk(3'd6, 5'd9, 32'hFFFF_FFFF, 5'd10, 32'h0, 5'd31, 32'h7, 1'b0), 32'hFFFF_FFFF, 32'h0, 3'd0};
    vecs[3] = '{mk(3'd5, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'hCAFE_F00D, 5'd1, 32'h0, 1'b0), 32'hDEAD_BEEF, 32'hCAFE_F00D, 3'd5};
    vecs[4] = '{mk(3'd0, 5'd31, 32'h8000_0000, 5'd30, 32'h7FFF_FFFF, 5'd0, 32'h1, 1'b0), 32'h8000_0000, 32'h7FFF_FFFF, 3'd0};
    vecs[5] = '{mk(3'd2, 5'd12, 32'h5555_5555, 5'd13, 32'hAAAA_AAAA, 5'd14, 32'h0, 1'b1), 32'h5555_5555, 32'h0, 3'd2};

    // Reset while an instruction is offered.
    rst_n = 0; flush = 0; out_ready = 1; in_valid = 1;
    cur = mk(3'd3, 5'd2, 32'h77, 5'd3, 32'h88, 5'd4, 32'h9, 1'b0);
    no_fwd(); model_reset();
    #2;
    chk("rst/out_valid", 32'(out_valid), 0);
    chk("rst/in_ready", 32'(in_ready), 1);
    chk("rst/A", A, 0);
    chk("rst/B", B, 0);
    chk("rst/ALU_control", 32'(ALU_control), 0);
    chk("rst/rd", 32'(out_rd_addr), 0);
    cycle(); cycle();
    chk("rst_edge/out_valid", 32'(out_valid), 0);
    rst_n = 1;
    cycle();
    chk("first_load/out_valid", 32'(out_valid), 1);
    chk("first_load/A", A, 32'h77);
    check_model("first_load");

    // Vector table: back-to-back loads at full throughput.
    foreach (vecs[k]) begin
      cur = vecs[k].in; in_valid = 1; out_ready = 1;
      cycle();
      chk($sformatf("vec%0d/out_valid", k), 32'(out_valid), 1);
      chk($sformatf("vec%0d/A", k), A, vecs[k].e_a);
      chk($sformatf("vec%0d/B", k), B, vecs[k].e_b);
      chk($sformatf("vec%0d/op", k), 32'(ALU_control), 32'(vecs[k].e_op));
      chk($sformatf("vec%0d/rd", k), 32'(out_rd_addr), 32'(vecs[k].in.rd));
    end

    // Stall: second instruction waits, first holds.
    i1 = mk(3'd1, 5'd3, 32'h10, 5'd4, 32'h20, 5'd5, 32'h0, 1'b0);
    i2 = mk(3'd4, 5'd6, 32'h60, 5'd7, 32'h70, 5'd8, 32'h0, 1'b0);
    cur = i1; in_valid = 1; out_ready = 1;
    cycle();
    cur = i2; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d/in_ready", c), 32'(in_ready), 0);
      chk($sformatf("stall%0d/A", c), A, 32'h10);
      chk($sformatf("stall%0d/op", c), 32'(ALU_control), 1);
      check_model($sformatf("stall%0d", c));
      cycle();
    end
    out_ready = 1; #1;
    chk("unstall/in_ready", 32'(in_ready), 1);
    cycle();
    chk("unstall/A", A, 32'h60);
    chk("unstall/op", 32'(ALU_control), 4);
    chk("unstall/out_valid", 32'(out_valid), 1);

    // Forwarding priority on a stalled instruction.
    cur = mk(3'd0, 5'd5, 32'h1111, 5'd6, 32'h2222, 5'd9, 32'h0, 1'b0);
    cycle();
    in_valid = 0; out_ready = 0;
    mem_fwd_we = 1; mem_fwd_addr = 5; mem_fwd_data = 32'hAAAA;
    wb_fwd_we = 1;  wb_fwd_addr = 5;  wb_fwd_data = 32'hBBBB;
    #1;
`ifdef ALU_OPERAND_FWD_EN
    chk("fwd_mem/A", A, 32'hAAAA);
`else
    chk("fwd_mem/A", A, 32'h1111);
`endif
    mem_fwd_we = 0; #1;
`ifdef ALU_OPERAND_FWD_EN
    chk("fwd_wb/A", A, 32'hBBBB);
`else
    chk("fwd_wb/A", A, 32'h1111);
`endif
    wb_fwd_addr = 6; #1;
    check_model("fwd_rs2");
    cur = mk(3'd0, 5'd0, 32'h3333, 5'd6, 32'h4444, 5'd9, 32'h0, 1'b0);
    in_valid = 1; out_ready = 1; no_fwd();
    cycle();
    mem_fwd_we = 1; mem_fwd_addr = 0; mem_fwd_data = 32'hAAAA;
    wb_fwd_we = 1;  wb_fwd_addr = 0;  wb_fwd_data = 32'hBBBB;
    #1;
    chk("fwd_x0/A", A, 32'h3333);

    // Immediate is never forwarded; 3'b111 captures as ADD.
    cur = mk(3'd7, 5'd1, 32'h1, 5'd6, 32'h6, 5'd2, 32'hFFFF_FFF0, 1'b1);
    cycle();
    mem_fwd_addr = 6; #1;
    chk("imm/B", B, 32'hFFFF_FFF0);
    chk("imm/op", 32'(ALU_control), 0);
    check_model("imm");
    no_fwd();

    // Flush alongside a load: never presented.
    cur = mk(3'd2, 5'd1, 32'hF1, 5'd2, 32'hF2, 5'd3, 32'h0, 1'b0);
    in_valid = 1; out_ready = 1; flush = 1;
    cycle();
    chk("flush_load/out_valid", 32'(out_valid), 0);
    flush = 0; in_valid = 0;
    cycle();
    chk("flush_load_after/out_valid", 32'(out_valid), 0);

    // Flush during a stall.
    in_valid = 1; cycle();
    in_valid = 0; out_ready = 0; flush = 1;
    cycle();
    chk("flush_stall/out_valid", 32'(out_valid), 0);
    flush = 0; out_ready = 1;
    cycle();
    chk("flush_stall_after/out_valid", 32'(out_valid), 0);

    // Asynchronous reset mid-stall, then first load after release.
    cur = mk(3'd3, 5'd4, 32'h44, 5'd5, 32'h55, 5'd6, 32'h0, 1'b0);
    in_valid = 1; cycle();
    out_ready = 0; cycle();
    rst_n = 0; #1; model_reset();
    chk("rst_mid/out_valid", 32'(out_valid), 0);
    chk("rst_mid/in_ready", 32'(in_ready), 1);
    chk("rst_mid/A", A, 0);
    chk("rst_mid/B", B, 0);
    cycle();
    rst_n = 1; #1;
    cycle();
    chk("rst_mid_reload/out_valid", 32'(out_valid), 1);
    chk("rst_mid_reload/A", A, 32'h44);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cur = mk(3'($urandom), 5'($urandom_range(0, 3)), $urandom,
               5'($urandom_range(0, 3)), $urandom, 5'($urandom),
               $urandom, 1'($urandom));
      mem_fwd_we = 1'($urandom); mem_fwd_addr = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
      wb_fwd_we  = 1'($urandom); wb_fwd_addr  = 5'($urandom_range(0, 3)); wb_fwd_data  = $urandom;
      #1;
      check_model($sformatf("rnd%0d", n));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
